// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the sequential restoring divider.
//   - state_t   : control FSM encoding (also exported on the debug port)
//   - DEFAULT_N : default operand width
//   - cnt_width : width of the quotient-bit counter for a given operand width
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_N = 8;

  // The counter must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_datapath.sv
// -----------------------------------------------------------------------------
// divider_datapath
//   A/Q/M/cnt registers and the trial subtractor of the restoring divider.
//   Driven by one-hot enables from the control FSM in the top level.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   ld_i            capture operands, clear A, load counter
//   shift_i         shift {A,Q} left by one, Q[0] <= 0
//   sub_i           trial subtract, set or restore, decrement counter
//   dividend_i      numerator   (read only while ld_i)
//   divisor_i       denominator (read only while ld_i)
//   dz_o            divisor_i is zero (meaningful while ld_i)
//   last_o          counter is 1, i.e. the current SUB produces the last bit
//   quotient_o      register Q
//   remainder_o     A[N-1:0]
// -----------------------------------------------------------------------------
module divider_datapath
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         shift_i,
  input  logic         sub_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         dz_o,
  output logic         last_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);

  localparam int CW = cnt_width(N);

  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    t;

  // Trial difference; its MSB set means A < M and the subtraction is undone.
  assign t      = a_q - {1'b0, m_q};
  assign dz_o   = (divisor_i == '0);
  assign last_o = (cnt_q == CW'(1));

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = CW'(N);
      m_d   = divisor_i;
      if (dz_o) begin
        // Divide by zero: all-ones quotient, dividend passed through as remainder.
        a_d = {1'b0, dividend_i};
        q_d = '1;
      end else begin
        a_d = '0;
        q_d = dividend_i;
      end
    end else if (shift_i) begin
      {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
    end else if (sub_i) begin
      cnt_d = cnt_q - CW'(1);
      if (!t[N]) begin
        a_d    = t;
        q_d[0] = 1'b1;
      end else begin
        q_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = q_q;
  assign remainder_o = a_q[N-1:0];

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//   Sequential unsigned restoring divider, two clocks per quotient bit.
//   quotient = dividend / divisor, remainder = dividend % divisor.
//   Handshake: start is sampled in IDLE; busy is high in LOAD/SHIFT/SUB; done
//   is high in DONE. The op completes when done rises; the requester must then
//   drop start, after which the FSM returns to IDLE (no retrigger while start
//   stays high). Results hold until the next LOAD.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           operation request
//   dividend        numerator, captured in LOAD
//   divisor         denominator, captured in LOAD
//   quotient        result quotient
//   remainder       result remainder
//   busy            operation in progress
//   done            result valid
//   div_by_zero     last captured divisor was zero
//   dbg_state       current FSM state (observation only)
// -----------------------------------------------------------------------------
module restoring_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output state_t       dbg_state
);

  state_t state_q;
  logic   div_by_zero_q;
  logic   dz;
  logic   last;

  divider_datapath #(.N(N)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .ld_i        (state_q == S_LOAD),
    .shift_i     (state_q == S_SHIFT),
    .sub_i       (state_q == S_SUB),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .dz_o        (dz),
    .last_o      (last),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_LOAD;
        S_LOAD: begin
          div_by_zero_q <= dz;
          state_q       <= dz ? S_DONE : S_SHIFT;
        end
        S_SHIFT: state_q <= S_SUB;
        S_SUB:   state_q <= last ? S_DONE : S_SHIFT;
        S_DONE:  if (!start) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode from the state register: no path from start to busy/done.
  assign busy        = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_SUB);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = div_by_zero_q;
  assign dbg_state   = state_q;

endmodule
